// File: rtl/serial_pattern_matcher.sv
//------------------------------------------------------------------------------
// Module      : serial_pattern_matcher
// Description : Runtime-programmable serial bit-pattern detector with
//               overlap control and a saturating match counter.
//               Optional MATCH_MASK_EN adds a per-bit don't-care mask.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_pattern_matcher #(
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
`ifdef MATCH_MASK_EN
    input  logic [MAX_LEN-1:0] cfg_mask,
`endif
    input  logic               bit_valid,
    input  logic               bit_in,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    // The oldest history bit never reaches the compare window, so it is not stored.
    logic [MAX_LEN-2:0] r_history;
    logic [LEN_W-1:0]   r_fill;
    logic               r_match;
    logic [CNT_W-1:0]   r_count;
    logic               r_armed;
`ifdef MATCH_MASK_EN
    logic [MAX_LEN-1:0] r_mask;
`endif

    logic [LEN_W-1:0]   w_len_cfg;
    logic [MAX_LEN-1:0] w_word;
    logic [LEN_W:0]     w_fill_inc;
    logic               w_filled;
    logic [MAX_LEN-1:0] w_len_mask;
    logic [MAX_LEN-1:0] w_care;
    logic               w_hit;
    logic [LEN_W-1:0]   w_fill_next;
    logic [CNT_W-1:0]   w_count_next;

    always_comb begin
        w_len_cfg = cfg_len;
        if (cfg_len == '0) begin
            w_len_cfg = c_ONE;
        end else if (cfg_len > c_MAX_LEN) begin
            w_len_cfg = c_MAX_LEN;
        end
    end

    assign w_word     = {r_history, bit_in};
    assign w_fill_inc = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
    assign w_filled   = (w_fill_inc >= {1'b0, r_len});

    always_comb begin
        w_len_mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_len_mask[i] = (i < int'(r_len));
        end
    end

`ifdef MATCH_MASK_EN
    assign w_care = w_len_mask & ~r_mask;
`else
    assign w_care = w_len_mask;
`endif

    assign w_hit = w_filled && (((w_word ^ r_pattern) & w_care) == '0);

    // Non-overlapping mode restarts the fill so the next hit needs len fresh bits.
    always_comb begin
        if (w_hit && !r_overlap) begin
            w_fill_next = '0;
        end else if (r_fill >= c_MAX_LEN) begin
            w_fill_next = c_MAX_LEN;
        end else begin
            w_fill_next = w_fill_inc[LEN_W-1:0];
        end
    end

    assign w_count_next = (w_hit && (r_count != c_CNT_MAX)) ? r_count + 1'b1 : r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pattern <= '0;
            r_len     <= c_ONE;
            r_overlap <= 1'b1;
            r_history <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_armed   <= 1'b0;
`ifdef MATCH_MASK_EN
            r_mask    <= '0;
`endif
        end else if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_len     <= w_len_cfg;
            r_overlap <= cfg_overlap;
            r_history <= '0;
            r_fill    <= '0;
            r_match   <= 1'b0;
            r_count   <= '0;
            r_armed   <= 1'b0;
`ifdef MATCH_MASK_EN
            r_mask    <= cfg_mask;
`endif
        end else if (bit_valid) begin
            r_history <= w_word[MAX_LEN-2:0];
            r_fill    <= w_fill_next;
            r_match   <= w_hit;
            r_count   <= w_count_next;
            r_armed   <= (w_fill_next >= r_len);
        end else begin
            r_match   <= 1'b0;
        end
    end

    assign match       = r_match;
    assign match_count = r_count;
    assign armed       = r_armed;

endmodule

`default_nettype wire
